// File: rtl/pwm_dt.sv
// Complementary half-bridge PWM with shadowed period/duty/dead-time settings.
// Settings apply glitch-free at the period wrap, or immediately while disabled.
module pwm_dt #(
    parameter int CNT_W      = 16,
    parameter int DT_W       = 8,
    parameter int PERIOD_DEF = 125,
    parameter int DUTY_DEF   = 50,
    parameter int DEAD_DEF   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] duty,
    input  logic [DT_W-1:0]  dead,
    output logic             out_hi,
    output logic             out_lo,
    output logic             cyc_start
);

    localparam logic [CNT_W-1:0] PER_RST  = (PERIOD_DEF < 2) ? CNT_W'(2) : CNT_W'(PERIOD_DEF);
    localparam logic [CNT_W-1:0] DUTY_RST = CNT_W'(DUTY_DEF);
    localparam logic [DT_W-1:0]  DEAD_RST = DT_W'(DEAD_DEF);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

    logic [CNT_W-1:0] per_a_q, per_a_d, duty_a_q, duty_a_d;
    logic [DT_W-1:0]  dead_a_q, dead_a_d;
    logic [CNT_W-1:0] per_p_q, per_p_d, duty_p_q, duty_p_d;
    logic [DT_W-1:0]  dead_p_q, dead_p_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DT_W-1:0]  hi_cnt_q, hi_cnt_d, lo_cnt_q, lo_cnt_d;
    logic             out_hi_q, out_hi_d, out_lo_q, out_lo_d, cyc_q, cyc_d;

    logic raw, raw_lo, reload, apply;

    always_comb begin
        per_a_d  = per_a_q;
        duty_a_d = duty_a_q;
        dead_a_d = dead_a_q;
        per_p_d  = per_p_q;
        duty_p_d = duty_p_q;
        dead_p_d = dead_p_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q - ONE;

        // Disabled acts like a permanent wrap: counter parked at P-1, pending applied.
        reload = !en || (cnt_q == '0);
        apply  = reload && pend_q;

        if (apply) begin
            per_a_d  = per_p_q;
            duty_a_d = duty_p_q;
            dead_a_d = dead_p_q;
            pend_d   = 1'b0;
            cnt_d    = per_p_q - ONE;
        end else if (reload) begin
            cnt_d = per_a_q - ONE;
        end

        // A load coinciding with a wrap lands in the shadow only; it waits one period.
        if (load) begin
            per_p_d  = (period < TWO) ? TWO : period;
            duty_p_d = duty;
            dead_p_d = dead;
            pend_d   = 1'b1;
        end

        raw    = en && (cnt_q < duty_a_q);
        raw_lo = en && !raw;

        hi_cnt_d = '0;
        if (raw) hi_cnt_d = (hi_cnt_q == '1) ? hi_cnt_q : hi_cnt_q + DT_W'(1);
        lo_cnt_d = '0;
        if (raw_lo) lo_cnt_d = (lo_cnt_q == '1) ? lo_cnt_q : lo_cnt_q + DT_W'(1);

        out_hi_d = raw && (hi_cnt_q >= dead_a_q);
        out_lo_d = raw_lo && (lo_cnt_q >= dead_a_q);
        cyc_d    = en && (cnt_q == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_a_q  <= PER_RST;
            duty_a_q <= DUTY_RST;
            dead_a_q <= DEAD_RST;
            per_p_q  <= PER_RST;
            duty_p_q <= DUTY_RST;
            dead_p_q <= DEAD_RST;
            pend_q   <= 1'b0;
            cnt_q    <= PER_RST - ONE;
            hi_cnt_q <= '0;
            lo_cnt_q <= '0;
            out_hi_q <= 1'b0;
            out_lo_q <= 1'b0;
            cyc_q    <= 1'b0;
        end else begin
            per_a_q  <= per_a_d;
            duty_a_q <= duty_a_d;
            dead_a_q <= dead_a_d;
            per_p_q  <= per_p_d;
            duty_p_q <= duty_p_d;
            dead_p_q <= dead_p_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            hi_cnt_q <= hi_cnt_d;
            lo_cnt_q <= lo_cnt_d;
            out_hi_q <= out_hi_d;
            out_lo_q <= out_lo_d;
            cyc_q    <= cyc_d;
        end
    end

    assign out_hi    = out_hi_q;
    assign out_lo    = out_lo_q;
    assign cyc_start = cyc_q;

endmodule

// File: tb/tb_pwm_dt.sv
// Scoreboard bench for pwm_dt: a phase-based reference model predicts each cycle's
// outputs into a queue; a monitor pops and compares one entry per clock.
module tb_pwm_dt;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] period = '0;
    logic [15:0] duty = '0;
    logic [7:0]  dead = '0;
    logic        out_hi, out_lo, cyc_start;

    always #5 clk = ~clk;

    pwm_dt #(
        .CNT_W(16), .DT_W(8), .PERIOD_DEF(125), .DUTY_DEF(50), .DEAD_DEF(5)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .period(period), .duty(duty), .dead(dead),
        .out_hi(out_hi), .out_lo(out_lo), .cyc_start(cyc_start)
    );

    typedef struct {
        bit hi;
        bit lo;
        bit cs;
    } exp_t;

    exp_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    // Reference model: position k within the current period (0 = first cycle),
    // plus a history of the raw drive levels to judge the dead-time window.
    int mP, mD, mDT, pP, pD, pDT, k;
    bit pend;
    logic [255:0] hh, lh;

    function automatic int clampP(int p);
        return (p < 2) ? 2 : p;
    endfunction

    // Output may be on only if its raw level was high this cycle and the dead_a cycles before.
    function automatic bit window_ok(logic [255:0] h, int d);
        for (int i = 0; i <= d; i++)
            if (!h[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_init();
        mP = 125; mD = 50; mDT = 5;
        pP = 125; pD = 50; pDT = 5;
        pend = 1'b0; k = 0;
        hh = '0; lh = '0;
        exp_q.delete();
    endtask

    task automatic model_step();
        int onset;
        bit r, rl;
        exp_t e;
        onset = (mD >= mP) ? 0 : mP - mD;
        r  = en && (k >= onset);
        rl = en && !r;
        hh = {hh[254:0], r};
        lh = {lh[254:0], rl};
        e.hi = window_ok(hh, mDT);
        e.lo = window_ok(lh, mDT);
        e.cs = en && (k == mP - 1);
        exp_q.push_back(e);
        if (!en || k == mP - 1) begin
            if (pend) begin
                mP = pP; mD = pD; mDT = pDT; pend = 1'b0;
            end
            k = 0;
        end else begin
            k++;
        end
        if (load) begin
            pP = clampP(int'(period)); pD = int'(duty); pDT = int'(dead); pend = 1'b1;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_init();
        else     model_step();
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_empty t=%0t: no expected entry for output sample", $time);
            end else begin
                e = exp_q.pop_front();
                if (out_hi !== e.hi || out_lo !== e.lo || cyc_start !== e.cs || (out_hi & out_lo)) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t: hi/lo/cyc got %b%b%b expected %b%b%b",
                             $time, out_hi, out_lo, cyc_start, e.hi, e.lo, e.cs);
                end
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ld(int p, int d, int dt);
        period = 16'(p); duty = 16'(d); dead = 8'(dt);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_wrap(int limit);
        int n = 0;
        while (!(en && k == mP - 1) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) begin
            vectors++; miscompares++;
            $display("FAIL wrap_timeout: got no wrap cycle within %0d required", limit);
        end
    endtask

    task automatic wait_hi(int limit);
        int n = 0;
        while (out_hi !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) begin
            vectors++; miscompares++;
            $display("FAIL out_hi_timeout: got out_hi=%b, required 1 within %0d cycles", out_hi, limit);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        cyc(375);                 // defaults: three 125-cycle periods
        cyc(30);
        ld(10, 3, 0);             // mid-period load, takes effect at wrap
        cyc(200);
        ld(10, 0, 2);             // duty 0: low side continuous
        cyc(60);
        ld(100, 200, 3);          // duty > period: high side continuous
        cyc(250);
        ld(60, 30, 40);           // pulses shorter than dead time suppressed
        cyc(200);
        ld(1, 1, 0);              // period clamped to 2
        cyc(40);
        ld(12, 5, 1);
        cyc(30);
        wait_wrap(200);
        ld(20, 8, 2);             // load in wrap cycle: applies one period later
        cyc(60);
        wait_hi(100);
        en = 1'b0;                // drop enable mid-pulse
        cyc(6);
        en = 1'b1;
        cyc(60);
        wait_hi(100);
        #1 rst = 1'b1;            // asynchronous reset mid-pulse
        #1;
        vectors++;
        if (out_hi !== 1'b0 || out_lo !== 1'b0 || cyc_start !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: hi/lo/cyc got %b%b%b required 000", out_hi, out_lo, cyc_start);
        end
        @(negedge clk);
        rst = 1'b0;
        cyc(300);
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) != 0)
                ld($urandom_range(0, 40), $urandom_range(0, 45), $urandom_range(0, 8));
            if ($urandom_range(0, 9) == 0) en = ~en;
            cyc($urandom_range(1, 80));
        end
        en = 1'b1;
        cyc(10);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
